multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting for mem_ready in one memory access.
REQ-002 Parameter SUPPORT_JUMP, default 1: when 1, JAL/JALR/LUI are decoded; when 0, those opcodes are illegal.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 opcode  input  7  opcode field of the instruction register, sampled in DECODE.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 mem_req  output  1  memory request, held high until accepted.
REQ-008 mem_we  output  1  write request, valid while mem_req is high.
REQ-009 ir_write, pc_write  output  1 each  load instruction register / program counter.
REQ-010 reg_write, mem_to_reg  output  1 each  register file write enable; write-back source select (1 = memory data).
REQ-011 alu_src_b  output  1  ALU operand B select (1 = immediate).
REQ-012 alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 pass immediate.
REQ-013 branch, jump  output  1 each  branch qualifier; unconditional PC redirect.
REQ-014 illegal, timeout  output  1 each  sticky error flags.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1 and pc_write=1 for that cycle; next DECODE.
REQ-017 DECODE: one cycle; legal opcode -> EXEC; any other opcode -> HALT with illegal=1.
REQ-018 Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch; plus 1101111 JAL, 1100111 JALR and 0110111 LUI if SUPPORT_JUMP=1.
REQ-019 EXEC alu_op/alu_src_b: R 10/0; I-ALU 00/1; load/store 00/1; branch 01/0; JAL/JALR 00/1; LUI 11/1.
REQ-020 EXEC next state: load/store -> MEM; branch -> FETCH with branch=1 for that cycle; R, I-ALU, LUI, JAL, JALR -> WB.
REQ-021 JAL/JALR additionally drive jump=1 and pc_write=1 in EXEC.
REQ-022 MEM: mem_req=1, mem_we=1 for store; on mem_ready, store -> FETCH and load -> WB.
REQ-023 WB: reg_write=1 for one cycle; mem_to_reg=1 only for load; next FETCH.
REQ-024 A wait counter clears on entry to FETCH or MEM and increments every cycle mem_req=1 and mem_ready=0.
REQ-025 When the counter reaches MEM_TIMEOUT without mem_ready, the block enters HALT with timeout=1 and drops mem_req in the next cycle.
REQ-026 mem_ready arriving in the same cycle as the counter reaching MEM_TIMEOUT counts as success; the timeout is not taken.
REQ-027 mem_ready is ignored whenever mem_req=0.
REQ-028 HALT: all enables deasserted, error flags held; exit only via reset.
REQ-029 Outputs are decoded from registered state and the registered opcode only; opcode changes outside DECODE have no effect.
REQ-030 Counter width is clog2(MEM_TIMEOUT+1); the counter saturates and never wraps.

Reset
REQ-031 reset_n low forces state FETCH, counter 0, illegal=0, timeout=0, and all enables and alu_op=00 asynchronously.
REQ-032 mem_req rises on the first clk edge after reset_n deasserts.
REQ-033 Reset asserted mid-access aborts the access; no write or reg_write pulse is emitted.

Structure
REQ-034 The opcode constants, state encoding and alu_op codes are defined in shared package riscv_ctrl_pkg.
REQ-035 The opcode-to-control decode is the single combinational sub-module ctrl_decode, instantiated once.

Verification
REQ-036 R-type 0110011 with mem_ready=1 in fetch -> FETCH, DECODE, EXEC (alu_op=10), WB (reg_write=1); 4 cycles.
REQ-037 Load 0000011 with 3-cycle memory wait in MEM -> WB with mem_to_reg=1; 8 cycles total.
REQ-038 Store 0100011 -> MEM with mem_we=1, no reg_write, then back to FETCH.
REQ-039 Opcode 1111111, and opcode 1101111 with SUPPORT_JUMP=0 -> HALT with illegal=1; mem_req stays 0 until reset.
REQ-040 MEM_TIMEOUT=4 with mem_ready held low -> timeout=1 after 4 wait cycles; mem_ready on cycle 4 -> no timeout.
REQ-041 reset_n pulsed low during MEM of a store -> mem_we drops immediately; next access is a fetch.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the state encoding, ALU operation codes, opcode constants and decoded-control bundle.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_PASS   = 2'b11
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Everything EXEC, MEM and WB need to know about the instruction class.
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_b;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jump;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: legality plus the per-class control bundle.
// Jump-type opcodes (JAL, JALR, LUI) are only legal when SUPPORT_JUMP is nonzero.
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int SUPPORT_JUMP = 1
) (
  input  logic [6:0] opcode,
  output logic       legal,
  output ctrl_t      ctrl
);

  always_comb begin
    legal = 1'b0;
    ctrl  = '0;
    case (opcode)
      OP_R: begin
        legal       = 1'b1;
        ctrl.alu_op = ALU_FUNCT;
      end
      OP_IMM: begin
        legal          = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
      end
      OP_LOAD: begin
        legal          = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.is_load   = 1'b1;
      end
      OP_STORE: begin
        legal          = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.is_store  = 1'b1;
      end
      OP_BRANCH: begin
        legal          = 1'b1;
        ctrl.alu_op    = ALU_BRANCH;
        ctrl.is_branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        if (SUPPORT_JUMP != 0) begin
          legal          = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          ctrl.alu_src_b = 1'b1;
          ctrl.is_jump   = 1'b1;
        end
      end
      OP_LUI: begin
        if (SUPPORT_JUMP != 0) begin
          legal          = 1'b1;
          ctrl.alu_op    = ALU_PASS;
          ctrl.alu_src_b = 1'b1;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with bounded memory waits.
// Errors (illegal opcode, memory timeout) park the unit in HALT until reset.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter int SUPPORT_JUMP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       jump,
  output logic       illegal,
  output logic       timeout
);

  localparam int             CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_n;
  logic          run;
  logic [CW-1:0] cnt;
  ctrl_t         ctrl_q;
  ctrl_t         dec_ctrl;
  logic          dec_legal;
  logic          illegal_q, timeout_q;
  logic          set_illegal, set_timeout;
  logic          wait_expired;

  ctrl_decode #(
    .SUPPORT_JUMP(SUPPORT_JUMP)
  ) u_decode (
    .opcode(opcode),
    .legal (dec_legal),
    .ctrl  (dec_ctrl)
  );

  assign wait_expired = !mem_ready && (cnt == CNT_LAST);
  assign illegal      = illegal_q;
  assign timeout      = timeout_q;

  // 'run' holds every output low until the first clock edge after reset releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      run       <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      run       <= 1'b1;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
      if (state == S_DECODE) ctrl_q <= dec_ctrl;
    end
  end

  // Wait counter restarts on every entry into a memory state and saturates at MEM_TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if ((state_n != state) && ((state_n == S_FETCH) || (state_n == S_MEM))) begin
      cnt <= '0;
    end else if (mem_req && !mem_ready && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_n     = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    branch      = 1'b0;
    jump        = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = S_DECODE;
          end else if (wait_expired) begin
            set_timeout = 1'b1;
            state_n     = S_HALT;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            state_n = S_EXEC;
          end else begin
            set_illegal = 1'b1;
            state_n     = S_HALT;
          end
        end
        S_EXEC: begin
          alu_op    = ctrl_q.alu_op;
          alu_src_b = ctrl_q.alu_src_b;
          if (ctrl_q.is_jump) begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end
          if (ctrl_q.is_load || ctrl_q.is_store) begin
            state_n = S_MEM;
          end else if (ctrl_q.is_branch) begin
            branch  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = ctrl_q.is_store;
          if (mem_ready) begin
            state_n = ctrl_q.is_store ? S_FETCH : S_WB;
          end else if (wait_expired) begin
            set_timeout = 1'b1;
            state_n     = S_HALT;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = ctrl_q.is_load;
          state_n    = S_FETCH;
        end
        S_HALT: begin
          state_n = S_HALT;
        end
        default: begin
          state_n = S_HALT;
        end
      endcase
    end
  end

endmodule
